clk_div_prog: RTL and testbench

Runtime-programmable integer clock divider with exact 50 % duty cycle for both odd and even divisors. It replaces the fixed divide-by-7 generator. Divisor changes are accepted through a load handshake and applied only at a period boundary, so the output never shows a runt pulse. The block sits in the clock-generation area and feeds derived clocks plus a same-domain tick strobe to downstream logic.

---
 rtl/clk_div_pkg.sv | 10 +
 rtl/clk_div_negext.sv | 16 +
 rtl/clk_div_prog.sv | 90 +++++++++
 tb/tb_clk_div_prog.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_prog shared definitions.
// Default width, reset divisor and divisor type.
package clk_div_pkg;

  localparam int W_DEF           = 8;
  localparam int DEFAULT_DIV_DEF = 7;

  typedef logic [W_DEF-1:0] div_t;

endpackage

// File: rtl/clk_div_negext.sv
// clk_div_prog falling-edge resample flop.
// Kept apart so negedge timing is constrained alone.
module clk_div_negext (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic q
);

  // resample on the falling edge, reset sampled on that edge
  always_ff @(negedge clk_in) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable 50% duty clock divider.
// New divisors switch only at period boundaries.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int W           = W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div_in,
  input  logic         div_load,
  output logic         div_ack,
  output logic         div_err,
  output logic [W-1:0] div_cur,
  output logic         clk_out,
  output logic         tick
);

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);

  logic [W-1:0] cnt;
  logic [W-1:0] div_q;
  logic [W-1:0] pend_div;
  logic [W-1:0] div_nxt;
  logic         pend_vld;
  logic         run;
  logic         clk_p;
  logic         clk_n;
  logic         ack_q;
  logic         err_q;
  logic         bnd;

  assign bnd     = !run || (cnt == div_q - ONE);
  assign div_nxt = pend_vld ? pend_div : div_q;

  // counter, phase, divisor switch and load handshake
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt      <= '0;
      run      <= 1'b0;
      clk_p    <= 1'b0;
      div_q    <= W'(DEFAULT_DIV);
      pend_div <= '0;
      pend_vld <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ack_q <= bnd & pend_vld;
      err_q <= div_load & (div_in == '0);
      if (bnd) begin
        div_q <= div_nxt;
        run   <= en;
        cnt   <= '0;
        clk_p <= en & (div_nxt >= TWO);
      end else begin
        cnt   <= cnt + ONE;
        clk_p <= (cnt + ONE) < (div_q >> 1);
      end
      if (div_load && div_in != '0) begin
        pend_div <= div_in;
        pend_vld <= 1'b1;
      end else if (bnd) begin
        pend_vld <= 1'b0;
      end
    end
  end

  clk_div_negext u_negext (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (clk_p),
    .q      (clk_n)
  );

  // pick the output shape from the divisor in effect
  always_comb begin
    clk_out = clk_p;
    if (div_q == ONE) clk_out = clk_in & run;
    else if (div_q[0]) clk_out = clk_p | clk_n;
  end

  assign tick    = run & (cnt == '0);
  assign div_ack = ack_q;
  assign div_err = err_q;
  assign div_cur = div_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// clk_div_prog directed bench.
// Each task drives one scenario and checks inline.
module tb_clk_div_prog;
  import clk_div_pkg::*;

  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic div_load = 1'b0;
  div_t div_in = '0;
  logic div_ack, div_err, clk_out, tick;
  div_t div_cur;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  clk_div_prog #(.W(8), .DEFAULT_DIV(7)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .div_ack  (div_ack),
    .div_err  (div_err),
    .div_cur  (div_cur),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  // expected {clk_out high half, clk_out low half, tick} at phase ph
  function automatic logic [2:0] exp_wave(int d, int ph);
    return {(2*ph < d), (2*ph+1 < d), (ph == 0)};
  endfunction

  // called just after a posedge; samples one full cycle
  task automatic sample_cycle(output logic [2:0] w, output logic a,
                              output logic e, output div_t c);
    w[2] = clk_out;
    w[0] = tick;
    a = div_ack;
    e = div_err;
    c = div_cur;
    @(negedge clk_in); #1;
    w[1] = clk_out;
    @(posedge clk_in); #1;
  endtask

  task automatic test_reset();
    logic [2:0] w; logic a, e; div_t c;
    rst = 1'b1; en = 1'b0;
    @(posedge clk_in); #1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rst = 1'b0;
      sample_cycle(w, a, e, c);
      if ({w, a, e, c} !== {3'b000, 1'b0, 1'b0, 8'd7}) begin
        errors++;
        $display("FAIL reset i=%0d got w=%b a=%b e=%b cur=%0d exp w=000 a=0 e=0 cur=7",
                 i, w, a, e, c);
      end
      checks++;
    end
  endtask

  task automatic test_default();
    logic [2:0] w; logic a, e; div_t c;
    en = 1'b1;
    sample_cycle(w, a, e, c);
    if (w !== 3'b000) begin
      errors++;
      $display("FAIL start_idle got %b exp 000", w);
    end
    checks++;
    for (int i = 0; i < 14; i++) begin
      sample_cycle(w, a, e, c);
      if (w !== exp_wave(7, i % 7)) begin
        errors++;
        $display("FAIL default_wave i=%0d got %b exp %b", i, w, exp_wave(7, i % 7));
      end
      checks++;
      if ({a, c} !== {1'b0, 8'd7}) begin
        errors++;
        $display("FAIL default_cur i=%0d got a=%b cur=%0d exp a=0 cur=7", i, a, c);
      end
      checks++;
    end
  endtask

  task automatic test_even();
    logic [2:0] w; logic a, e; div_t c; int d, ph;
    for (int i = 0; i < 15; i++) begin
      div_load = (i == 0);
      div_in = 8'd4;
      sample_cycle(w, a, e, c);
      div_load = 1'b0;
      if (i < 7) begin d = 7; ph = i; end
      else begin d = 4; ph = (i - 7) % 4; end
      if (w !== exp_wave(d, ph)) begin
        errors++;
        $display("FAIL even_wave i=%0d got %b exp %b", i, w, exp_wave(d, ph));
      end
      checks++;
      if ({a, c} !== {(i == 7), div_t'(d)}) begin
        errors++;
        $display("FAIL even_ack i=%0d got a=%b cur=%0d exp a=%b cur=%0d",
                 i, a, c, (i == 7), d);
      end
      checks++;
    end
  endtask

  task automatic test_bypass();
    logic [2:0] w; logic a, e; div_t c; int d, ph;
    for (int i = 0; i < 18; i++) begin
      div_load = (i == 0) || (i == 6);
      div_in = (i == 0) ? 8'd1 : 8'd5;
      sample_cycle(w, a, e, c);
      div_load = 1'b0;
      if (i < 4) begin d = 4; ph = i; end
      else if (i < 8) begin d = 1; ph = 0; end
      else begin d = 5; ph = (i - 8) % 5; end
      if (w !== exp_wave(d, ph)) begin
        errors++;
        $display("FAIL bypass_wave i=%0d got %b exp %b", i, w, exp_wave(d, ph));
      end
      checks++;
      if ({a, c} !== {(i == 4 || i == 8), div_t'(d)}) begin
        errors++;
        $display("FAIL bypass_ack i=%0d got a=%b cur=%0d exp a=%b cur=%0d",
                 i, a, c, (i == 4 || i == 8), d);
      end
      checks++;
    end
  endtask

  task automatic test_invalid();
    logic [2:0] w; logic a, e; div_t c;
    for (int i = 0; i < 10; i++) begin
      div_load = (i == 0);
      div_in = 8'd0;
      sample_cycle(w, a, e, c);
      div_load = 1'b0;
      if (w !== exp_wave(5, i % 5)) begin
        errors++;
        $display("FAIL invalid_wave i=%0d got %b exp %b", i, w, exp_wave(5, i % 5));
      end
      checks++;
      if ({a, e, c} !== {1'b0, (i == 1), 8'd5}) begin
        errors++;
        $display("FAIL invalid_err i=%0d got a=%b e=%b cur=%0d exp a=0 e=%b cur=5",
                 i, a, e, c, (i == 1));
      end
      checks++;
    end
  endtask

  task automatic test_double();
    logic [2:0] w; logic a, e; div_t c; int d, ph;
    for (int i = 0; i < 23; i++) begin
      div_load = (i == 0) || (i == 2);
      div_in = (i == 0) ? 8'd6 : 8'd9;
      sample_cycle(w, a, e, c);
      div_load = 1'b0;
      if (i < 5) begin d = 5; ph = i; end
      else begin d = 9; ph = (i - 5) % 9; end
      if (w !== exp_wave(d, ph)) begin
        errors++;
        $display("FAIL double_wave i=%0d got %b exp %b", i, w, exp_wave(d, ph));
      end
      checks++;
      if ({a, e, c} !== {(i == 5), 1'b0, div_t'(d)}) begin
        errors++;
        $display("FAIL double_ack i=%0d got a=%b e=%b cur=%0d exp a=%b e=0 cur=%0d",
                 i, a, e, c, (i == 5), d);
      end
      checks++;
    end
  endtask

  task automatic test_enable();
    logic [2:0] w, x; logic a, e; div_t c; int d;
    for (int i = 0; i < 27; i++) begin
      div_load = (i == 0);
      div_in = 8'd7;
      en = (i < 11) || (i >= 19);
      sample_cycle(w, a, e, c);
      div_load = 1'b0;
      if (i < 9) begin d = 9; x = exp_wave(9, i); end
      else if (i < 16) begin d = 7; x = exp_wave(7, i - 9); end
      else if (i < 20) begin d = 7; x = 3'b000; end
      else begin d = 7; x = exp_wave(7, i - 20); end
      if (w !== x) begin
        errors++;
        $display("FAIL enable_wave i=%0d got %b exp %b", i, w, x);
      end
      checks++;
      if ({a, c} !== {(i == 9), div_t'(d)}) begin
        errors++;
        $display("FAIL enable_ack i=%0d got a=%b cur=%0d exp a=%b cur=%0d",
                 i, a, c, (i == 9), d);
      end
      checks++;
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [2:0] w, x; logic a, e; div_t c;
    for (int i = 0; i < 19; i++) begin
      div_load = (i == 0);
      div_in = 8'd4;
      rst = (i == 2) || (i == 3);
      sample_cycle(w, a, e, c);
      div_load = 1'b0;
      if (i < 3) x = exp_wave(7, i);
      else if (i == 3) x = {w[2], 2'b00};
      else if (i == 4) x = 3'b000;
      else x = exp_wave(7, (i - 5) % 7);
      if (w !== x) begin
        errors++;
        $display("FAIL rstmid_wave i=%0d got %b exp %b", i, w, x);
      end
      checks++;
      if ({a, c} !== {1'b0, 8'd7}) begin
        errors++;
        $display("FAIL rstmid_cur i=%0d got a=%b cur=%0d exp a=0 cur=7", i, a, c);
      end
      checks++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_default();
    test_even();
    test_bypass();
    test_invalid();
    test_double();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
